spi_slave_param: RTL and testbench
==================================

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter WIDTH, default 8: bits per SPI word; legal range 2..32.
REQ-002 Parameter CPOL, default 0: spi_clk idle level.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 shifted first, 0 = bit 0 first.
REQ-005 Parameter RX_DEPTH, default 4: receive FIFO depth, power of two, 2..16; used only when SPI_SLAVE_RX_FIFO_EN is defined.
REQ-006 Parameter TX_IDLE, default all-zero: word sent when no tx word is available.
REQ-007 clk  in  1  system clock; every internal register is clocked on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 spi_clk  in  1  SPI clock, asynchronous to clk.
REQ-010 cs_n  in  1  chip select, active-low, asynchronous.
REQ-011 mosi  in  1  master-out data, asynchronous.
REQ-012 miso  out  1  slave-out data.
REQ-013 tx_data  in  WIDTH  next word to transmit.
REQ-014 tx_valid  in  1  tx_data holds a word.
REQ-015 tx_ready  out  1  one-cycle pulse: tx_data consumed this cycle.
REQ-016 rx_data  out  WIDTH  received word at the head of the receive buffer.
REQ-017 rx_valid  out  1  rx_data holds a word.
REQ-018 rx_ready  in  1  consumer accepts rx_data when rx_valid=1.
REQ-019 rx_overrun  out  1  one-cycle pulse: a completed word was dropped.
REQ-020 tx_underrun  out  1  one-cycle pulse: TX_IDLE was loaded because tx_valid=0.

Function
REQ-021 spi_clk, cs_n and mosi SHALL each pass through a 2-flop synchroniser; edges SHALL be detected on the synchronised spi_clk only.
REQ-022 Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
REQ-023 State machine SHALL be IDLE -> LOAD -> SHIFT -> IDLE; the synchronised cs_n high forces IDLE from any state.
REQ-024 IDLE -> LOAD on synchronised cs_n falling; LOAD lasts 1 cycle and loads the tx shift register from tx_data (tx_ready=1) if tx_valid=1, else from TX_IDLE (tx_underrun=1).
REQ-025 In SHIFT, each sample edge SHALL shift mosi into the rx shift register in MSB_FIRST order and increment a bit counter of width clog2(WIDTH).
REQ-026 With CPHA=0, miso SHALL present the first tx bit from LOAD onward and advance on each trailing edge; with CPHA=1, miso SHALL advance on each leading edge, including the first.
REQ-027 On the sample edge of bit WIDTH-1, the bit counter SHALL wrap to 0, the word SHALL be pushed to the receive buffer on the next cycle, and the tx register SHALL reload as in REQ-024 with no gap, giving back-to-back words while cs_n stays low.
REQ-028 A push when the receive buffer is full SHALL drop the new word, keep the buffer unchanged and pulse rx_overrun.
REQ-029 A pop (rx_valid and rx_ready) SHALL occur in the same cycle as a push; when the buffer is full this SHALL NOT count as overrun.
REQ-030 When cs_n rises mid-word, the partial word SHALL be discarded, the counter cleared and no rx_valid, rx_overrun or tx_ready generated; a tx word already loaded is consumed and lost.
REQ-031 miso SHALL be 0 while in IDLE.
REQ-032 rx_valid SHALL assert no later than 5 clk cycles after the raw spi_clk sample edge of the last bit; spi_clk high and low phases are each at least 3 clk periods.

Reset
REQ-033 In the cycle after rst=1 is sampled: state IDLE, counters 0, buffer empty, miso=0, rx_valid=0, rx_data=0, tx_ready=0, rx_overrun=0, tx_underrun=0, synchronisers set to cs_n=1 and spi_clk=CPOL.
REQ-034 rst asserted mid-word SHALL abandon the word with no output pulses; after rst releases, a new word begins only on a fresh cs_n falling edge.

Configuration
REQ-035 Macro SPI_SLAVE_RX_FIFO_EN defined: the receive buffer is a RX_DEPTH-entry FIFO; rx_data is the FIFO head.
REQ-036 Macro SPI_SLAVE_RX_FIFO_EN undefined: the receive buffer is a single holding register (depth 1), RX_DEPTH is ignored, and the interface is identical.

Verification
REQ-037 Mode 0, WIDTH=8, MSB first, tx_data=0xAB valid; master sends 0x33 -> rx_data=0x33 with one rx_valid, one tx_ready pulse, master receives 0xAB.
REQ-038 CPOL=1, CPHA=1, MSB_FIRST=0, WIDTH=12; master sends 0x5A3 -> rx_data=0x5A3; master receives tx_data=0x0F0 sent LSB first.
REQ-039 With FIFO enabled and RX_DEPTH=4, rx_ready=0, 5 back-to-back words 0x01..0x05 -> 0x01..0x04 are held and one rx_overrun pulse occurs on the 5th; with FIFO disabled, 0x01 is held and there are 4 overrun pulses.
REQ-040 tx_valid=0 at cs_n falling, TX_IDLE=0xFF -> tx_underrun pulse and master receives 0xFF.
REQ-041 cs_n rises after 5 of 8 bits, then a full word 0xC3 is sent -> only 0xC3 appears with no stray rx_valid.
REQ-042 rst pulsed after 4 bits, then a new frame 0x7E is sent -> outputs are at reset values during the reset and rx_data=0x7E afterwards.

Source files
------------

// File: rtl/spi_slave_param.sv
// Parameterised SPI slave (mode set by CPOL/CPHA) with a clk-domain receive buffer.
// Define SPI_SLAVE_RX_FIFO_EN for an RX_DEPTH-entry receive FIFO; otherwise a single holding register.
module spi_slave_param #(
    parameter int               WIDTH     = 8,
    parameter bit               CPOL      = 1'b0,
    parameter bit               CPHA      = 1'b0,
    parameter bit               MSB_FIRST = 1'b1,
    parameter int               RX_DEPTH  = 4,
    parameter logic [WIDTH-1:0] TX_IDLE   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_clk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             tx_underrun
);

    localparam int CW = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("spi_slave_param: WIDTH must be 2..32");
    end
    if (RX_DEPTH < 2 || RX_DEPTH > 16 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spi_slave_param: RX_DEPTH must be a power of two in 2..16");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t           state;
    logic             sclk_s1, sclk_s2, sclk_prev;
    logic             cs_s1, cs_s2, cs_prev;
    logic             mosi_s1, mosi_s2;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] push_word;
    logic             push_pending;
    logic             leading, trailing, sample_edge, shift_edge;
    logic             last_bit, load_now;
    logic             pop, full, push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1   <= CPOL;
            sclk_s2   <= CPOL;
            sclk_prev <= CPOL;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
        end else begin
            sclk_s1   <= spi_clk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            cs_s1     <= cs_n;
            cs_s2     <= cs_s1;
            cs_prev   <= cs_s2;
            mosi_s1   <= mosi;
            mosi_s2   <= mosi_s1;
        end
    end

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign leading     = (sclk_s2 != CPOL) && (sclk_prev == CPOL);
    assign trailing    = (sclk_s2 == CPOL) && (sclk_prev != CPOL);
    assign sample_edge = CPHA ? trailing : leading;
    assign shift_edge  = CPHA ? leading : trailing;
    assign last_bit    = (bit_cnt == CW'(WIDTH - 1));
    assign rx_next     = MSB_FIRST ? {rx_shift[WIDTH-2:0], mosi_s2} : {mosi_s2, rx_shift[WIDTH-1:1]};
    assign load_word   = tx_valid ? tx_data : TX_IDLE;

    // The tx word is taken either in LOAD or on the final sample edge, so back-to-back words need no gap.
    assign load_now    = !rst && !cs_s2 &&
                         ((state == LOAD) || ((state == SHIFT) && sample_edge && last_bit));
    assign tx_ready    = load_now && tx_valid;
    assign tx_underrun = load_now && !tx_valid;

    // tx_shift holds the bits not yet driven onto miso; each shift edge presents the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            miso         <= 1'b0;
            push_pending <= 1'b0;
            push_word    <= '0;
        end else begin
            push_pending <= 1'b0;
            if (cs_s2) begin
                state   <= IDLE;
                bit_cnt <= '0;
                miso    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_prev) state <= LOAD;
                    end
                    LOAD: begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        if (!CPHA) begin
                            miso     <= first_bit(load_word);
                            tx_shift <= shift_out(load_word);
                        end else begin
                            tx_shift <= load_word;
                        end
                    end
                    SHIFT: begin
                        if (sample_edge) begin
                            rx_shift <= rx_next;
                            if (last_bit) begin
                                bit_cnt      <= '0;
                                push_pending <= 1'b1;
                                push_word    <= rx_next;
                                tx_shift     <= load_word;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        if (shift_edge) begin
                            miso     <= first_bit(tx_shift);
                            tx_shift <= shift_out(tx_shift);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign pop     = rx_valid && rx_ready;
    assign push_ok = push_pending && (!full || pop);

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int AW = $clog2(RX_DEPTH);

    logic [WIDTH-1:0] mem [RX_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;

    assign full     = (count == (AW + 1)'(RX_DEPTH));
    assign rx_valid = (count != '0);
    assign rx_data  = mem[rd_ptr];

    // A simultaneous pop frees the slot the push needs, so a full FIFO only overruns without one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rx_overrun <= 1'b0;
            for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
        end else begin
            rx_overrun <= push_pending && full && !pop;
            if (push_ok) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
`else
    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;

    assign full     = hold_valid;
    assign rx_valid = hold_valid;
    assign rx_data  = hold_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= push_pending && full && !pop;
            if (push_ok) begin
                hold_data  <= push_word;
                hold_valid <= 1'b1;
            end else if (pop) begin
                hold_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_param.sv
// Scoreboard bench for spi_slave_param: a mode-0 MSB-first 8-bit slave and a CPOL=1/CPHA=1 LSB-first 12-bit slave.
`timescale 1ns/1ps
module tb_spi_slave_param;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mosi;
    logic        sclk0, cs0_n, miso0, tx_valid0, tx_ready0, rx_valid0, rx_ready0, rx_overrun0, tx_underrun0;
    logic [7:0]  tx_data0, rx_data0;
    logic        sclk1, cs1_n, miso1, tx_valid1, tx_ready1, rx_valid1, rx_ready1, rx_overrun1, tx_underrun1;
    logic [11:0] tx_data1, rx_data1;

    int          n_vec = 0;
    int          n_err = 0;
    int          txr0 = 0, und0 = 0, ovr0 = 0, txr1 = 0, und1 = 0;
    logic [31:0] m_tx [8];
    logic [31:0] m_rx [8];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    always #5 clk = ~clk;

    spi_slave_param #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
                      .RX_DEPTH(4), .TX_IDLE(8'hFF)) u_dut0 (
        .clk(clk), .rst(rst), .spi_clk(sclk0), .cs_n(cs0_n), .mosi(mosi), .miso(miso0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .rx_overrun(rx_overrun0), .tx_underrun(tx_underrun0)
    );

    spi_slave_param #(.WIDTH(12), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0),
                      .RX_DEPTH(4), .TX_IDLE(12'h000)) u_dut1 (
        .clk(clk), .rst(rst), .spi_clk(sclk1), .cs_n(cs1_n), .mosi(mosi), .miso(miso1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .rx_overrun(rx_overrun1), .tx_underrun(tx_underrun1)
    );

    always @(posedge clk) begin
        if (tx_ready0)    txr0++;
        if (tx_underrun0) und0++;
        if (rx_overrun0)  ovr0++;
        if (tx_ready1)    txr1++;
        if (tx_underrun1) und1++;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sclk(input int sel, input logic v);
        if (sel == 0) sclk0 = v; else sclk1 = v;
    endtask

    task automatic set_cs(input int sel, input logic v);
        if (sel == 0) cs0_n = v; else cs1_n = v;
    endtask

    // Master model: words from m_tx, received bits into m_rx; the last word may be cut short.
    task automatic spi_frame(input int sel, input int nwords, input int last_bits,
                             input bit raise_cs, input bit one_tx);
        int   w    = (sel != 0) ? 12 : 8;
        logic cpol = (sel != 0);
        logic cpha = (sel != 0);
        bit   msb  = (sel == 0);
        set_cs(sel, 1'b0);
        wait_clk(H);
        if (one_tx) begin
            if (sel != 0) tx_valid1 = 1'b0; else tx_valid0 = 1'b0;
        end
        for (int k = 0; k < nwords; k++) begin
            int nb = (k == nwords - 1) ? last_bits : w;
            m_rx[k] = '0;
            for (int i = 0; i < nb; i++) begin
                int b = msb ? (w - 1 - i) : i;
                if (!cpha) begin
                    mosi = m_tx[k][b];
                    wait_clk(H);
                    set_sclk(sel, !cpol);
                    m_rx[k][b] = (sel != 0) ? miso1 : miso0;
                    wait_clk(H);
                    set_sclk(sel, cpol);
                end else begin
                    set_sclk(sel, !cpol);
                    mosi = m_tx[k][b];
                    wait_clk(H);
                    set_sclk(sel, cpol);
                    m_rx[k][b] = (sel != 0) ? miso1 : miso0;
                    wait_clk(H);
                end
            end
        end
        if (raise_cs) begin
            wait_clk(H);
            set_cs(sel, 1'b1);
            wait_clk(H);
        end
    endtask

    task automatic pop_rx(input int sel, output logic [31:0] got, output bit ok);
        ok  = 1'b0;
        got = 'x;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (((sel != 0) ? rx_valid1 : rx_valid0) === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            got = (sel != 0) ? {20'd0, rx_data1} : {24'd0, rx_data0};
            if (sel != 0) rx_ready1 = 1'b1; else rx_ready0 = 1'b1;
            @(negedge clk);
            rx_ready0 = 1'b0;
            rx_ready1 = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] obs [9];
        string       nm  [9];
        rst = 1'b1;
        wait_clk(3);
        obs = '{32'(miso0), 32'(rx_valid0), 32'(rx_data0), 32'(tx_ready0), 32'(rx_overrun0),
                32'(tx_underrun0), 32'(miso1), 32'(rx_valid1), 32'(rx_data1)};
        nm  = '{"miso0", "rx_valid0", "rx_data0", "tx_ready0", "rx_overrun0",
                "tx_underrun0", "miso1", "rx_valid1", "rx_data1"};
        for (int i = 0; i < 9; i++) begin
            n_vec++;
            if (obs[i] !== 32'd0) begin
                n_err++;
                $display("[TB] FAIL reset_%s got %0h want 0", nm[i], obs[i]);
            end
        end
        rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_mode0();
        int          b_txr = txr0, b_und = und0;
        logic [31:0] exp, got;
        bit          ok;
        tx_data0  = 8'hAB;
        tx_valid0 = 1'b1;
        m_tx[0]   = 32'h33;
        exp_q0.push_back(32'h33);
        spi_frame(0, 1, 8, 1'b1, 1'b1);
        n_vec++;
        if (m_rx[0] !== 32'hAB) begin n_err++; $display("[TB] FAIL mode0_miso_word got %0h want ab", m_rx[0]); end
        n_vec++;
        if (txr0 - b_txr !== 1) begin n_err++; $display("[TB] FAIL mode0_tx_ready_pulses got %0d want 1", txr0 - b_txr); end
        // The end-of-word reload finds tx_valid low, so it underruns once.
        n_vec++;
        if (und0 - b_und !== 1) begin n_err++; $display("[TB] FAIL mode0_underrun_pulses got %0d want 1", und0 - b_und); end
        n_vec++;
        if (miso0 !== 1'b0) begin n_err++; $display("[TB] FAIL mode0_idle_miso got %b want 0", miso0); end
        while (exp_q0.size() != 0) begin
            exp = exp_q0.pop_front();
            pop_rx(0, got, ok);
            n_vec++;
            if (!ok || got !== exp) begin n_err++; $display("[TB] FAIL mode0_rx got %0h want %0h seen %0b", got, exp, ok); end
        end
        n_vec++;
        if (rx_valid0 !== 1'b0) begin n_err++; $display("[TB] FAIL mode0_single_rx_valid got %b want 0", rx_valid0); end
    endtask

    task automatic test_cpha1_lsb();
        int          b_txr = txr1, b_und = und1;
        logic [31:0] exp, got;
        bit          ok;
        tx_data1  = 12'h0F0;
        tx_valid1 = 1'b1;
        m_tx[0]   = 32'h5A3;
        exp_q1.push_back(32'h5A3);
        spi_frame(1, 1, 12, 1'b1, 1'b1);
        n_vec++;
        if (m_rx[0] !== 32'h0F0) begin n_err++; $display("[TB] FAIL cpha1_miso_word got %0h want 0f0", m_rx[0]); end
        n_vec++;
        if (txr1 - b_txr !== 1) begin n_err++; $display("[TB] FAIL cpha1_tx_ready_pulses got %0d want 1", txr1 - b_txr); end
        n_vec++;
        if (und1 - b_und !== 1) begin n_err++; $display("[TB] FAIL cpha1_underrun_pulses got %0d want 1", und1 - b_und); end
        while (exp_q1.size() != 0) begin
            exp = exp_q1.pop_front();
            pop_rx(1, got, ok);
            n_vec++;
            if (!ok || got !== exp) begin n_err++; $display("[TB] FAIL cpha1_rx got %0h want %0h seen %0b", got, exp, ok); end
        end
        n_vec++;
        if (rx_valid1 !== 1'b0) begin n_err++; $display("[TB] FAIL cpha1_rx_valid_after got %b want 0", rx_valid1); end
    endtask

    task automatic test_underrun();
        int          b_txr = txr0, b_und = und0;
        logic [31:0] exp, got;
        bit          ok;
        tx_valid0 = 1'b0;
        m_tx[0]   = 32'h96;
        exp_q0.push_back(32'h96);
        spi_frame(0, 1, 8, 1'b1, 1'b0);
        n_vec++;
        if (m_rx[0] !== 32'hFF) begin n_err++; $display("[TB] FAIL underrun_miso_word got %0h want ff", m_rx[0]); end
        // LOAD and the end-of-word reload both underrun.
        n_vec++;
        if (und0 - b_und !== 2) begin n_err++; $display("[TB] FAIL underrun_pulses got %0d want 2", und0 - b_und); end
        n_vec++;
        if (txr0 - b_txr !== 0) begin n_err++; $display("[TB] FAIL underrun_tx_ready got %0d want 0", txr0 - b_txr); end
        while (exp_q0.size() != 0) begin
            exp = exp_q0.pop_front();
            pop_rx(0, got, ok);
            n_vec++;
            if (!ok || got !== exp) begin n_err++; $display("[TB] FAIL underrun_rx got %0h want %0h seen %0b", got, exp, ok); end
        end
    endtask

    task automatic test_back_to_back();
        int          b_ovr = ovr0, b_und = und0, want_ovr;
        logic [31:0] exp, got;
        bit          ok;
        tx_valid0 = 1'b0;
        for (int i = 0; i < 5; i++) m_tx[i] = 32'(i + 1);
`ifdef SPI_SLAVE_RX_FIFO_EN
        for (int i = 1; i <= 4; i++) exp_q0.push_back(32'(i));
        want_ovr = 1;
`else
        exp_q0.push_back(32'h01);
        want_ovr = 4;
`endif
        spi_frame(0, 5, 8, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (m_rx[i] !== 32'hFF) begin n_err++; $display("[TB] FAIL b2b_miso_word%0d got %0h want ff", i, m_rx[i]); end
        end
        n_vec++;
        if (ovr0 - b_ovr !== want_ovr) begin n_err++; $display("[TB] FAIL b2b_overrun_pulses got %0d want %0d", ovr0 - b_ovr, want_ovr); end
        n_vec++;
        if (und0 - b_und !== 6) begin n_err++; $display("[TB] FAIL b2b_underrun_pulses got %0d want 6", und0 - b_und); end
        while (exp_q0.size() != 0) begin
            exp = exp_q0.pop_front();
            pop_rx(0, got, ok);
            n_vec++;
            if (!ok || got !== exp) begin n_err++; $display("[TB] FAIL b2b_rx got %0h want %0h seen %0b", got, exp, ok); end
        end
        n_vec++;
        if (rx_valid0 !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_rx_valid_after got %b want 0", rx_valid0); end
    endtask

    task automatic test_abort();
        int          b_ovr = ovr0;
        logic [31:0] exp, got;
        bit          ok;
        tx_valid0 = 1'b0;
        m_tx[0]   = 32'h5C;
        spi_frame(0, 1, 5, 1'b1, 1'b0);
        wait_clk(10);
        n_vec++;
        if (rx_valid0 !== 1'b0) begin n_err++; $display("[TB] FAIL abort_rx_valid got %b want 0", rx_valid0); end
        n_vec++;
        if (ovr0 - b_ovr !== 0) begin n_err++; $display("[TB] FAIL abort_overrun got %0d want 0", ovr0 - b_ovr); end
        m_tx[0] = 32'hC3;
        exp_q0.push_back(32'hC3);
        spi_frame(0, 1, 8, 1'b1, 1'b0);
        while (exp_q0.size() != 0) begin
            exp = exp_q0.pop_front();
            pop_rx(0, got, ok);
            n_vec++;
            if (!ok || got !== exp) begin n_err++; $display("[TB] FAIL abort_rx got %0h want %0h seen %0b", got, exp, ok); end
        end
        n_vec++;
        if (rx_valid0 !== 1'b0) begin n_err++; $display("[TB] FAIL abort_stray_rx_valid got %b want 0", rx_valid0); end
    endtask

    task automatic test_reset_midword();
        logic [31:0] obs [6];
        string       nm  [6];
        logic [31:0] exp, got;
        bit          ok;
        tx_valid0 = 1'b0;
        m_tx[0]   = 32'hA5;
        spi_frame(0, 1, 4, 1'b0, 1'b0);
        rst = 1'b1;
        wait_clk(2);
        obs = '{32'(miso0), 32'(rx_valid0), 32'(rx_data0), 32'(tx_ready0), 32'(rx_overrun0), 32'(tx_underrun0)};
        nm  = '{"miso0", "rx_valid0", "rx_data0", "tx_ready0", "rx_overrun0", "tx_underrun0"};
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (obs[i] !== 32'd0) begin
                n_err++;
                $display("[TB] FAIL midrst_%s got %0h want 0", nm[i], obs[i]);
            end
        end
        cs0_n = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(10);
        n_vec++;
        if (rx_valid0 !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_rx_valid_after got %b want 0", rx_valid0); end
        m_tx[0] = 32'h7E;
        exp_q0.push_back(32'h7E);
        spi_frame(0, 1, 8, 1'b1, 1'b0);
        while (exp_q0.size() != 0) begin
            exp = exp_q0.pop_front();
            pop_rx(0, got, ok);
            n_vec++;
            if (!ok || got !== exp) begin n_err++; $display("[TB] FAIL midrst_rx got %0h want %0h seen %0b", got, exp, ok); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        mosi      = 1'b0;
        sclk0     = 1'b0;
        cs0_n     = 1'b1;
        sclk1     = 1'b1;
        cs1_n     = 1'b1;
        tx_data0  = '0;
        tx_valid0 = 1'b0;
        rx_ready0 = 1'b0;
        tx_data1  = '0;
        tx_valid1 = 1'b0;
        rx_ready1 = 1'b0;
        test_reset();
        test_mode0();
        test_cpha1_lsb();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_reset_midword();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
